// File: rtl/sliced_alu.sv
// Digit-serial ALU: processes DIGIT bits per clock, LSB first, and publishes
// RESULT and flags together in a final cycle with a one-cycle DONE pulse.
module sliced_alu #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             sub,
   input  logic             cin,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   localparam int unsigned N  = WIDTH / DIGIT;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   localparam logic [2:0] OP_NOR  = 3'b000;
   localparam logic [2:0] OP_NAND = 3'b001;
   localparam logic [2:0] OP_OR   = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;
   localparam logic [2:0] OP_SUM  = 3'b110;
   localparam logic [2:0] OP_LESS = 3'b111;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] part;
   logic [2:0]       op_r;
   logic             carry_r;
   logic             ovf_r;

   logic [DIGIT-1:0] ad;
   logic [DIGIT-1:0] bd;
   logic [DIGIT-1:0] sum_c;
   logic [DIGIT-1:0] dig_c;
   logic             c;
   logic             c_top;
   logic             carry_c;
   logic             ovf_c;

   logic [WIDTH-1:0] fin_res_c;
   logic             fin_cout_c;
   logic             fin_ovf_c;

   // B is pre-inverted at accept time for subtraction and for the LESS compare
   logic             inv_b_c;
   assign inv_b_c = (op == OP_LESS) || ((op == OP_SUM) && sub);

   // One digit of ripple-carry add plus the bitwise functions
   always_comb begin
      ad    = a_sh[DIGIT-1:0];
      bd    = b_sh[DIGIT-1:0];
      c     = carry_r;
      c_top = 1'b0;
      sum_c = '0;
      for (int unsigned i = 0; i < DIGIT; i++) begin
         if (i == DIGIT - 1) c_top = c;
         sum_c[i] = ad[i] ^ bd[i] ^ c;
         c        = (ad[i] & bd[i]) | (ad[i] & c) | (bd[i] & c);
      end
      carry_c = c;
      ovf_c   = c_top ^ c;
      case (op_r)
         OP_NOR:  dig_c = ~(ad | bd);
         OP_NAND: dig_c = ~(ad & bd);
         OP_OR:   dig_c = ad | bd;
         OP_AND:  dig_c = ad & bd;
         OP_XOR:  dig_c = ad ^ bd;
         OP_XNOR: dig_c = ~(ad ^ bd);
         default: dig_c = sum_c;
      endcase
   end

   // Final result and flags; carry/overflow registers hold the MSB digit's values
   always_comb begin
      fin_res_c  = part;
      fin_cout_c = 1'b0;
      fin_ovf_c  = 1'b0;
      if (op_r == OP_SUM) begin
         fin_cout_c = carry_r;
         fin_ovf_c  = ovf_r;
      end else if (op_r == OP_LESS) begin
         fin_res_c = WIDTH'(part[WIDTH-1] ^ ovf_r);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         a_sh    <= '0;
         b_sh    <= '0;
         part    <= '0;
         op_r    <= '0;
         carry_r <= 1'b0;
         ovf_r   <= 1'b0;
         result  <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
         zero    <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= RUN;
                  busy    <= 1'b1;
                  cnt     <= '0;
                  a_sh    <= a;
                  b_sh    <= b ^ {WIDTH{inv_b_c}};
                  op_r    <= op;
                  carry_r <= (op == OP_SUM) ? cin : (op == OP_LESS);
                  ovf_r   <= 1'b0;
                  part    <= '0;
               end
            end
            RUN: begin
               a_sh    <= a_sh >> DIGIT;
               b_sh    <= b_sh >> DIGIT;
               part    <= (part >> DIGIT) | (WIDTH'(dig_c) << (WIDTH - DIGIT));
               carry_r <= carry_c;
               ovf_r   <= ovf_c;
               cnt     <= cnt + CW'(1);
               if (cnt == LAST) state <= FIN;
            end
            FIN: begin
               state  <= IDLE;
               busy   <= 1'b0;
               done   <= 1'b1;
               result <= fin_res_c;
               cout   <= fin_cout_c;
               ovf    <= fin_ovf_c;
               zero   <= (fin_res_c == '0);
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/sliced_alu.md
SLICED_ALU -- requirements
Module: sliced_alu

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter DIGIT, default 4, bits processed per clock; WIDTH SHALL be an integer multiple of DIGIT, N = WIDTH/DIGIT.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 START  input  1  request; sampled only in IDLE.
REQ-006 A, B  input  WIDTH  operands, latched when START is accepted.
REQ-007 OP  input  3  function select {C3,C2,C1}: 000 NOR, 001 NAND, 010 OR, 011 AND, 100 XOR, 101 XNOR, 110 SUM, 111 LESS (signed set-less-than).
REQ-008 SUB  input  1  for SUM, B is XORed with SUB per bit before addition.
REQ-009 CIN  input  1  carry into bit 0 for SUM; subtraction requires SUB=1, CIN=1.
REQ-010 RESULT  output  WIDTH  registered result, held until next completion.
REQ-011 COUT, OVF, ZERO  output  1 each  carry-out of MSB, signed overflow, RESULT==0.
REQ-012 BUSY  output  1  high whenever state is not IDLE.
REQ-013 DONE  output  1  one-cycle pulse when RESULT and flags update.

Function
REQ-014 FSM states IDLE, RUN, FIN; transitions IDLE->RUN on START, RUN->FIN after N digit cycles, FIN->IDLE unconditionally.
REQ-015 On START accept (edge e0), A, B, OP, SUB, CIN SHALL be latched and the digit counter cleared; later input changes SHALL not affect the operation.
REQ-016 At edges e1..eN, digit k = 0..N-1 (LSB first) SHALL be computed and written into an internal partial-result register; the carry register SHALL chain between digits.
REQ-017 Carry register initial value SHALL be CIN for SUM, 1 for LESS, 0 for logic ops.
REQ-018 For LESS, the internal adder SHALL use B inverted and carry-in 1, regardless of SUB and CIN.
REQ-019 At edge eN+1 (FIN), RESULT, COUT, OVF, ZERO SHALL be updated together and DONE SHALL be high for exactly the following cycle.
REQ-020 Latency: DONE SHALL be high in the cycle after edge eN+1, i.e. N+1 edges after the accept edge (5 for defaults).
REQ-021 SUM: RESULT = A + (B^{WIDTH{SUB}}) + CIN mod 2^WIDTH; COUT = final carry; OVF = carry into MSB XOR carry out of MSB.
REQ-022 LESS: RESULT = {WIDTH-1 zeros, S_msb XOR V}, where S and V are the difference and overflow of A-B; COUT = OVF = 0.
REQ-023 Logic ops: bitwise per OP; COUT = OVF = 0.
REQ-024 ZERO SHALL be computed from the final RESULT value for every OP.
REQ-025 START while BUSY SHALL be ignored with no effect on the operation in flight.
REQ-026 START high in the DONE cycle (state IDLE) SHALL be accepted; back-to-back operations issue every N+2 cycles.
REQ-027 Between completions, RESULT and flags SHALL hold their last values; intermediate digits SHALL not be visible on RESULT.

Reset
REQ-028 RST_N low SHALL immediately force IDLE, and set RESULT, COUT, OVF, BUSY, DONE to 0 and ZERO to 1.
REQ-029 Reset mid-RUN or mid-FIN SHALL abandon the operation; no DONE for it SHALL be produced.
REQ-030 First START SHALL be accepted on the first rising edge with RST_N high.

Verification (WIDTH=16, DIGIT=4)
REQ-031 OP=110, A=0x7FFF, B=0x0001, SUB=0, CIN=0 -> RESULT=0x8000, OVF=1, COUT=0, ZERO=0, DONE 5 edges after accept.
REQ-032 OP=110, A=0x0005, B=0x0005, SUB=1, CIN=1 -> RESULT=0x0000, ZERO=1, COUT=1, OVF=0.
REQ-033 OP=111, A=0x8000, B=0x0001 -> RESULT=0x0001; swap operands -> RESULT=0x0000, ZERO=1.
REQ-034 OP=000, A=0x00FF, B=0x0F0F -> RESULT=0xF000, COUT=OVF=0.
REQ-035 START again 2 cycles after accept with different operands -> ignored; first result delivered unchanged.
REQ-036 RST_N low 2 cycles into RUN -> BUSY=0, RESULT=0, ZERO=1, no DONE; next START completes normally.
